// File: rtl/shift_request_gen_pkg.sv
// Shared gearbox definitions: lockout FSM states, default timing, counter sizing.
package gearbox_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    LOCKOUT = 1'b1
  } gear_state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 500;
  localparam int unsigned GAP_DEFAULT      = 2500;
  localparam int unsigned DROP_W           = 4;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/shift_request_gen_if.sv
// Pad inputs and conditioned request outputs between the pads and the gearbox FSM.
interface shift_request_gen_if;
  import gearbox_pkg::*;

  logic              ena;
  logic              btn_up;
  logic              btn_down;
  logic              btn_brake;
  logic              shift_up;
  logic              shift_down;
  logic              brake;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output ena, btn_up, btn_down, btn_brake,
    input  shift_up, shift_down, brake, busy, drop_cnt
  );

  modport slave (
    input  ena, btn_up, btn_down, btn_brake,
    output shift_up, shift_down, brake, busy, drop_cnt
  );

endinterface

// File: rtl/shift_request_gen_debounce_sync.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer with a
// registered rising-edge flag on the accepted level.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned          CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // The change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = sync_q;
      rise_d   = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (ena) begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/shift_request_gen.sv
// Conditions the up/down/brake pads into rate-limited single-cycle shift requests,
// with brake priority, simultaneous-press rejection and post-shift lockout.
module shift_request_gen
  import gearbox_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GAP_CYCLES      = GAP_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  shift_request_gen_if.slave bus
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic up_stable, up_ev;
  logic dn_stable, dn_ev;
  logic brake_lvl, brake_rise;
  logic unused_levels;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.btn_up),
    .stable(up_stable), .rise(up_ev)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.btn_down),
    .stable(dn_stable), .rise(dn_ev)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brake (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.btn_brake),
    .stable(brake_lvl), .rise(brake_rise)
  );

  assign unused_levels = up_stable ^ dn_stable ^ brake_rise;

  gear_state_e       state_q;
  logic [CNT_W-1:0]  gap_q;
  logic              shift_up_q, shift_down_q, busy_q;
  logic [DROP_W-1:0] drop_q;
  logic              drop_req;

  // A cycle yields at most one drop regardless of how many events it carries.
  always_comb begin
    drop_req = 1'b0;
    case (state_q)
      IDLE:    drop_req = (up_ev & dn_ev) | (up_ev & brake_lvl);
      LOCKOUT: drop_req = up_ev | dn_ev;
      default: drop_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
    end else if (bus.ena) begin
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      if (drop_req && (drop_q != DROP_MAX)) begin
        drop_q <= drop_q + DROP_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (up_ev && dn_ev) begin
            state_q <= IDLE;
          end else if (up_ev && !brake_lvl) begin
            shift_up_q <= 1'b1;
            busy_q     <= 1'b1;
            gap_q      <= '0;
            state_q    <= LOCKOUT;
          end else if (dn_ev) begin
            shift_down_q <= 1'b1;
            busy_q       <= 1'b1;
            gap_q        <= '0;
            state_q      <= LOCKOUT;
          end
        end
        LOCKOUT: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            gap_q   <= '0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end else begin
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
    end
  end

  assign bus.shift_up   = shift_up_q;
  assign bus.shift_down = shift_down_q;
  assign bus.brake      = brake_lvl;
  assign bus.busy       = busy_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_shift_request_gen.sv
// Directed bench for shift_request_gen with DEBOUNCE_CYCLES=4, GAP_CYCLES=8.
module tb_shift_request_gen;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  shift_request_gen_if bus ();

  shift_request_gen #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_brake = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_brake = 1'b0;
    step(2);
    chk("rst_shift_up", 8'(bus.shift_up), 8'd0);
    chk("rst_shift_down", 8'(bus.shift_down), 8'd0);
    chk("rst_brake", 8'(bus.brake), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_drop", 8'(bus.drop_cnt), 8'd0);
    rst_n = 1'b1;

    // Clean up press
    bus.btn_up = 1'b1;
    step(6);
    chk("up_before_pulse", 8'(bus.shift_up), 8'd0);
    step(1);
    chk("up_pulse", 8'(bus.shift_up), 8'd1);
    chk("up_busy_rise", 8'(bus.busy), 8'd1);
    chk("up_drop", 8'(bus.drop_cnt), 8'd0);
    step(1);
    chk("up_pulse_end", 8'(bus.shift_up), 8'd0);
    chk("up_busy_hold", 8'(bus.busy), 8'd1);
    step(6);
    chk("up_busy_last", 8'(bus.busy), 8'd1);
    step(1);
    chk("up_busy_fall", 8'(bus.busy), 8'd0);
    bus.btn_up = 1'b0;
    step(10);

    // Bounce, then settle high
    for (int i = 0; i < 5; i++) begin
      bus.btn_up = 1'b1;
      step(2);
      chk("bounce_hi", 8'(bus.shift_up), 8'd0);
      bus.btn_up = 1'b0;
      step(2);
      chk("bounce_lo", 8'(bus.shift_up), 8'd0);
    end
    bus.btn_up = 1'b1;
    step(6);
    chk("bounce_early", 8'(bus.shift_up), 8'd0);
    step(1);
    chk("bounce_pulse", 8'(bus.shift_up), 8'd1);
    step(1);
    chk("bounce_pulse_end", 8'(bus.shift_up), 8'd0);
    step(10);
    bus.btn_up = 1'b0;
    step(10);

    // Brake priority
    bus.btn_brake = 1'b1;
    step(5);
    chk("brake_early", 8'(bus.brake), 8'd0);
    step(1);
    chk("brake_level", 8'(bus.brake), 8'd1);
    bus.btn_up = 1'b1;
    step(7);
    chk("brake_up_blocked", 8'(bus.shift_up), 8'd0);
    chk("brake_up_drop", 8'(bus.drop_cnt), 8'd1);
    chk("brake_up_busy", 8'(bus.busy), 8'd0);
    bus.btn_down = 1'b1;
    step(6);
    chk("brake_down_early", 8'(bus.shift_down), 8'd0);
    step(1);
    chk("brake_down_pulse", 8'(bus.shift_down), 8'd1);
    chk("brake_down_busy", 8'(bus.busy), 8'd1);
    step(8);
    chk("brake_down_busy_end", 8'(bus.busy), 8'd0);
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_brake = 1'b0;
    step(8);
    chk("brake_release", 8'(bus.brake), 8'd0);

    // Simultaneous press, lockout drop, saturation
    do_reset();
    chk("sim_drop_clear", 8'(bus.drop_cnt), 8'd0);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step(7);
    chk("sim_no_up", 8'(bus.shift_up), 8'd0);
    chk("sim_no_down", 8'(bus.shift_down), 8'd0);
    chk("sim_busy", 8'(bus.busy), 8'd0);
    chk("sim_drop", 8'(bus.drop_cnt), 8'd1);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(8);
    bus.btn_up = 1'b1;
    step(2);
    bus.btn_down = 1'b1;
    step(5);
    chk("lock_valid_up", 8'(bus.shift_up), 8'd1);
    step(1);
    chk("lock_drop_before", 8'(bus.drop_cnt), 8'd1);
    step(1);
    chk("lock_drop_after", 8'(bus.drop_cnt), 8'd2);
    chk("lock_no_down", 8'(bus.shift_down), 8'd0);
    step(8);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(8);
    for (int i = 0; i < 20; i++) begin
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b1;
      step(8);
      chk("sat_drop", 8'(bus.drop_cnt), 8'((3 + i > 15) ? 15 : 3 + i));
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      step(8);
    end
    chk("sat_busy", 8'(bus.busy), 8'd0);

    // Event on the cycle busy falls
    do_reset();
    bus.btn_up = 1'b1;
    step(7);
    chk("edge_first_pulse", 8'(bus.shift_up), 8'd1);
    step(2);
    bus.btn_down = 1'b1;
    step(6);
    chk("edge_busy_fell", 8'(bus.busy), 8'd0);
    chk("edge_down_early", 8'(bus.shift_down), 8'd0);
    step(1);
    chk("edge_down_pulse", 8'(bus.shift_down), 8'd1);
    chk("edge_busy_again", 8'(bus.busy), 8'd1);
    chk("edge_no_drop", 8'(bus.drop_cnt), 8'd0);

    // Async reset mid-lockout, release with up held
    step(2);
    chk("rst_mid_busy_pre", 8'(bus.busy), 8'd1);
    bus.btn_down = 1'b0;
    rst_n        = 1'b0;
    #2;
    chk("rst_mid_busy", 8'(bus.busy), 8'd0);
    chk("rst_mid_down", 8'(bus.shift_down), 8'd0);
    chk("rst_mid_up", 8'(bus.shift_up), 8'd0);
    chk("rst_mid_drop", 8'(bus.drop_cnt), 8'd0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("rst_held_early", 8'(bus.shift_up), 8'd0);
    step(1);
    chk("rst_held_pulse", 8'(bus.shift_up), 8'd1);
    step(10);

    // Enable freeze during debounce
    do_reset();
    bus.btn_up = 1'b1;
    step(4);
    bus.ena = 1'b0;
    step(10);
    chk("ena_frozen_up", 8'(bus.shift_up), 8'd0);
    chk("ena_frozen_busy", 8'(bus.busy), 8'd0);
    bus.ena = 1'b1;
    step(2);
    chk("ena_resume_early", 8'(bus.shift_up), 8'd0);
    step(1);
    chk("ena_resume_pulse", 8'(bus.shift_up), 8'd1);
    chk("ena_resume_busy", 8'(bus.busy), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_request_gen.md
# shift_request_gen

Input conditioner that turns the raw shift-up, shift-down and brake pads into clean, rate-limited requests for the gearbox state machine. It sits between the `ui_in` pads and the gearbox FSM on the slow (divided) clock domain. Every pad passes through synchronisation and debouncing. The block then applies request arbitration (brake priority, simultaneous-press rejection, post-shift lockout) and emits single-cycle shift pulses plus a debounced brake level.

## Interface
- `DEBOUNCE_CYCLES`, default 500: consecutive stable synchronised samples required to accept a level change (20 ms at 25 kHz).
- `GAP_CYCLES`, default 2500: lockout length after an issued shift pulse (100 ms at 25 kHz).
- `clk` input 1: the divided slow clock; all state is on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `ena` input 1: block enable.
- `btn_up` input 1: raw shift-up pad, asynchronous.
- `btn_down` input 1: raw shift-down pad, asynchronous.
- `btn_brake` input 1: raw brake pad, asynchronous.
- `shift_up` output 1: one-cycle upshift request pulse.
- `shift_down` output 1: one-cycle downshift request pulse.
- `brake` output 1: debounced brake level.
- `busy` output 1: high while in the lockout state.
- `drop_cnt` output 4: saturating count of rejected requests.

## Operation
- Per input: a 2-flop synchroniser, then a debouncer.
  - The debouncer holds `stable` and a counter.
  - The counter clears whenever the synchronised value equals `stable`.
  - When it differs for `DEBOUNCE_CYCLES` consecutive cycles, `stable` takes the synchronised value and the counter clears.
- A rising edge of stable up or stable down is a request event; falling edges generate nothing.
- `brake` equals the stable brake value.
- State machine `IDLE` → `LOCKOUT` → `IDLE`.
- In `IDLE`:
  - An up event with brake stable low: pulse `shift_up`, go to `LOCKOUT`.
  - An up event while brake stable high: dropped, `drop_cnt`+1.
  - A down event: always accepted (brake does not block downshift), pulse `shift_down`, go to `LOCKOUT`.
  - Up and down events in the same cycle: both rejected, no pulse, `drop_cnt`+1 once, stay `IDLE`.
- In `LOCKOUT`:
  - A gap counter runs from 0; at `GAP_CYCLES`-1 the FSM returns to `IDLE`.
  - Every event during lockout is dropped, `drop_cnt`+1 per cycle containing at least one event.
- `drop_cnt` saturates at 15 and never wraps; it clears only on reset.
- `ena` low:
  - Synchronisers keep running.
  - Debounce counters, gap counter and FSM freeze.
  - `shift_up`/`shift_down` are forced 0 and no drops are counted.
  - `brake` holds its last value.
- Reset values: all synchroniser, stable and counter flops 0, FSM `IDLE`, `shift_up`=`shift_down`=`brake`=`busy`=0, `drop_cnt`=0.
- A button held high through reset release is treated as a new press and yields a pulse after normal debounce latency.

## Timing
- Counter width `CNT_W` = `$clog2(max(DEBOUNCE_CYCLES, GAP_CYCLES)+1)`; comparisons are unsigned and exact.
- Press latency: the raw input is first sampled high at edge 1. Stable rises at edge `DEBOUNCE_CYCLES`+2. The registered pulse is high in the cycle after edge `DEBOUNCE_CYCLES`+3, for exactly one cycle.
- `busy` rises on the same edge as the pulse and stays high `GAP_CYCLES` cycles.
- An event arriving on the cycle `busy` falls is accepted (`IDLE` is evaluated that cycle).
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no output change.
- Async `rst_n` assertion mid-debounce or mid-lockout clears everything immediately. Pulses are cut combinationally by the reset flops.

## Structure
- Shared package `gearbox_pkg`:
  - FSM state enum (`IDLE`, `LOCKOUT`).
  - Default timing constants `DEBOUNCE_DEFAULT`=500 and `GAP_DEFAULT`=2500.
  - `DROP_W`=4.
- One sub-module `debounce_sync` (synchroniser + debouncer, parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst_n`, `ena`, `raw`, `stable`, `rise`), instantiated three times.
- Arbitration, lockout FSM and drop counter live in the top.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `GAP_CYCLES`=8.
- Clean up press: `btn_up` high from edge 1, brake 0 → `shift_up` high only in the cycle after edge 7. `busy` then stays high for 8 cycles. `drop_cnt`=0.
- Bounce: `btn_up` toggles 1/0 every 2 cycles for 20 cycles, then settles high → exactly one `shift_up` pulse, 7 edges after settling.
- Brake priority: brake held high and debounced, then an up press → no pulse, `drop_cnt`=1. A subsequent down press → `shift_down` pulse.
- Simultaneous: up and down rise on the same edge → no pulses, `drop_cnt`=1, `busy`=0. A second down press in lockout after a valid shift → `drop_cnt`+1. Twenty such drops → `drop_cnt`=15, saturated.
- Lockout boundary: the second press's event lands exactly on the cycle `busy` falls → accepted, pulse issued, `busy` re-asserts.
- Reset and enable:
  - Assert `rst_n`=0 mid-lockout → all outputs 0 immediately.
  - Release with `btn_up` held → pulse 7 edges after release.
  - `ena`=0 during debounce → no pulse until `ena` returns, then the count resumes from its frozen value.
